// File: rtl/fpu_ss_wb_arbiter_pkg.sv
// Shared types for the FPU_SS writeback arbiter: source tags, holding-slot entry
// and the cv-x-if result payload.
package fpu_ss_wb_arbiter_pkg;
  localparam int X_ID_WIDTH = 4;
  localparam int FLEN       = 32;
  localparam int NUM_SRC    = 2;

  typedef enum logic {WbFpu = 1'b0, WbMem = 1'b1} wb_src_e;

  typedef struct packed {
    logic [4:0]            addr;
    logic                  rd_is_fp;
    logic [X_ID_WIDTH-1:0] id;
  } fpu_tag_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic                  we;
    logic [FLEN/8-1:0]     be;
  } mem_metadata_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [FLEN-1:0]       data;
    logic [4:0]            rd;
    logic                  we;
    logic [2:0]            ecswe;
    logic                  exc;
    logic [5:0]            exccode;
    logic                  dbg;
    logic                  err;
  } x_result_t;

  // we: the entry writes its destination; rd_is_fp selects FP regfile vs core GPR.
  typedef struct packed {
    logic [FLEN-1:0]       data;
    logic [4:0]            rd;
    logic                  rd_is_fp;
    logic                  we;
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            fflags;
    logic                  err;
  } wb_entry_t;

  localparam logic [2:0] ECSWE_FS_DIRTY = 3'b010;
endpackage

// File: rtl/fpu_ss_wb_arbiter_if.sv
// Writeback side of the arbiter: cv-x-if result channel, FP regfile port and fflags.
interface fpu_ss_wb_arbiter_if;
  import fpu_ss_wb_arbiter_pkg::*;

  logic            x_result_valid;
  logic            x_result_ready;
  x_result_t       x_result;
  logic            fpr_we;
  logic [4:0]      fpr_waddr;
  logic [FLEN-1:0] fpr_wdata;
  logic            fflags_we;
  logic [4:0]      fflags;

  modport master (
    output x_result_valid, x_result, fpr_we, fpr_waddr, fpr_wdata, fflags_we, fflags,
    input  x_result_ready
  );

  modport slave (
    input  x_result_valid, x_result, fpr_we, fpr_waddr, fpr_wdata, fflags_we, fflags,
    output x_result_ready
  );
endinterface

// File: rtl/fpu_ss_wb_arbiter_slot.sv
// One-entry holding register; a retiring slot can be refilled in the same cycle.
module fpu_ss_wb_slot
  import fpu_ss_wb_arbiter_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      in_valid,
  input  wb_entry_t in_entry,
  output logic      in_ready,
  input  logic      retire,
  output logic      vld_q,
  output wb_entry_t entry_q
);
  assign in_ready = ~vld_q | retire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= 1'b0;
      entry_q <= '0;
    end else if (in_valid && in_ready) begin
      vld_q   <= 1'b1;
      entry_q <= in_entry;
    end else if (retire) begin
      vld_q   <= 1'b0;
    end
  end
endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// Shares the FP regfile write port and the X-result channel between fpnew and the
// load path using one holding slot per source and a round-robin grant.
module fpu_ss_wb_arbiter
  import fpu_ss_wb_arbiter_pkg::*;
#(
  parameter bit MEM_FIRST = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fpu_valid_i,
  output logic                fpu_ready_o,
  input  logic [FLEN-1:0]     fpu_result_i,
  input  fpu_tag_t            fpu_tag_i,
  input  logic [4:0]          fpu_status_i,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [FLEN-1:0]     mem_rdata_i,
  input  mem_metadata_t       mem_meta_i,
  input  logic                mem_err_i,
  fpu_ss_wb_arbiter_if.master wb,
  output logic                busy_o
);
  logic      [NUM_SRC-1:0] in_vld, in_rdy, retire, slot_vld;
  wb_entry_t [NUM_SRC-1:0] in_entry, slot_entry;
  wb_src_e                 rr_q, gnt;
  wb_entry_t               g_e;
  logic                    x_vld, hs, fpr_wr;
  logic                    unused_be;

  assign unused_be = ^mem_meta_i.be;

  always_comb begin
    in_entry[WbFpu]          = '0;
    in_entry[WbFpu].data     = fpu_result_i;
    in_entry[WbFpu].rd       = fpu_tag_i.addr;
    in_entry[WbFpu].rd_is_fp = fpu_tag_i.rd_is_fp;
    in_entry[WbFpu].we       = 1'b1;
    in_entry[WbFpu].id       = fpu_tag_i.id;
    in_entry[WbFpu].fflags   = fpu_status_i;

    // A faulting load must not update the destination register.
    in_entry[WbMem]          = '0;
    in_entry[WbMem].data     = mem_rdata_i;
    in_entry[WbMem].rd       = mem_meta_i.rd;
    in_entry[WbMem].rd_is_fp = 1'b1;
    in_entry[WbMem].we       = mem_meta_i.we & ~mem_err_i;
    in_entry[WbMem].id       = mem_meta_i.id;
    in_entry[WbMem].err      = mem_err_i;
  end

  assign in_vld[WbFpu] = fpu_valid_i;
  assign in_vld[WbMem] = mem_valid_i;
  assign fpu_ready_o   = in_rdy[WbFpu];
  assign mem_ready_o   = in_rdy[WbMem];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
    fpu_ss_wb_slot u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .in_valid (in_vld[s]),
      .in_entry (in_entry[s]),
      .in_ready (in_rdy[s]),
      .retire   (retire[s]),
      .vld_q    (slot_vld[s]),
      .entry_q  (slot_entry[s])
    );
  end

  // Grant only looks at registered slot state, so arrivals never preempt and the
  // grant holds steady under backpressure.
  always_comb begin
    if (&slot_vld)           gnt = rr_q;
    else if (slot_vld[WbMem]) gnt = WbMem;
    else                     gnt = WbFpu;
  end

  assign x_vld         = |slot_vld;
  assign hs            = x_vld & wb.x_result_ready;
  assign retire[WbFpu] = hs & (gnt == WbFpu);
  assign retire[WbMem] = hs & (gnt == WbMem);
  assign g_e           = x_vld ? slot_entry[gnt] : '0;
  assign fpr_wr        = g_e.we & g_e.rd_is_fp;

  always_ff @(posedge clk_i) begin
    if (rst_i)   rr_q <= wb_src_e'(MEM_FIRST);
    else if (hs) rr_q <= (gnt == WbFpu) ? WbMem : WbFpu;
  end

  always_comb begin
    wb.x_result         = '0;
    wb.x_result.id      = g_e.id;
    wb.x_result.data    = g_e.data;
    wb.x_result.rd      = g_e.rd;
    wb.x_result.we      = g_e.we & ~g_e.rd_is_fp;
    wb.x_result.ecswe   = fpr_wr ? ECSWE_FS_DIRTY : 3'b000;
    wb.x_result.err     = g_e.err;
  end

  assign wb.x_result_valid = x_vld;
  assign wb.fpr_we         = hs & fpr_wr;
  assign wb.fpr_waddr      = g_e.rd;
  assign wb.fpr_wdata      = g_e.data;
  assign wb.fflags_we      = retire[WbFpu];
  assign wb.fflags         = retire[WbFpu] ? g_e.fflags : 5'd0;
  assign busy_o            = x_vld;
endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Scoreboard bench for the writeback arbiter: tests push expected retirements in
// arbitration order, a negedge monitor pops and compares them at each handshake.
module tb_fpu_ss_wb_arbiter;
  import fpu_ss_wb_arbiter_pkg::*;

  typedef struct {
    logic        fpr_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  id;
    logic        xwe;
    logic        chk_x;
    logic [4:0]  xrd;
    logic [31:0] xdata;
    logic [2:0]  ecswe;
    logic        err;
    logic        fflags_we;
    logic [4:0]  fflags;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fpu_valid, fpu_ready, mem_valid, mem_ready, mem_err, busy;
  logic [31:0]   fpu_result, mem_rdata;
  fpu_tag_t      fpu_tag;
  logic [4:0]    fpu_status;
  mem_metadata_t mem_meta;
  exp_t          exp_q[$];
  exp_t          me;
  int            checks = 0, errors = 0, n_ret = 0;

  fpu_ss_wb_arbiter_if wb ();

  fpu_ss_wb_arbiter #(.MEM_FIRST(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready), .fpu_result_i(fpu_result),
    .fpu_tag_i(fpu_tag), .fpu_status_i(fpu_status),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_rdata_i(mem_rdata),
    .mem_meta_i(mem_meta), .mem_err_i(mem_err),
    .wb(wb.master), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t exp_fpu(logic [4:0] addr, logic is_fp, logic [3:0] id,
                                   logic [31:0] res, logic [4:0] st);
    exp_t e;
    e.fpr_we = is_fp; e.waddr = addr; e.wdata = res; e.id = id;
    e.xwe = ~is_fp; e.chk_x = ~is_fp; e.xrd = addr; e.xdata = res;
    e.ecswe = is_fp ? 3'b010 : 3'b000; e.err = 1'b0;
    e.fflags_we = 1'b1; e.fflags = st;
    return e;
  endfunction

  function automatic exp_t exp_mem(logic [4:0] rd, logic we, logic [3:0] id,
                                   logic [31:0] rdata, logic err);
    exp_t e;
    e.fpr_we = we & ~err; e.waddr = rd; e.wdata = rdata; e.id = id;
    e.xwe = 1'b0; e.chk_x = 1'b0; e.xrd = 5'd0; e.xdata = 32'd0;
    e.ecswe = (we & ~err) ? 3'b010 : 3'b000; e.err = err;
    e.fflags_we = 1'b0; e.fflags = 5'd0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (wb.x_result_valid && wb.x_result_ready) begin
        n_ret++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_retire: got id=%0d, required no retirement", wb.x_result.id);
        end else begin
          me = exp_q.pop_front();
          if (wb.fpr_we !== me.fpr_we) begin
            errors++; $display("FAIL fpr_we: got %b required %b (id %0d)", wb.fpr_we, me.fpr_we, me.id);
          end
          if (me.fpr_we) begin
            checks++;
            if ({wb.fpr_waddr, wb.fpr_wdata} !== {me.waddr, me.wdata}) begin
              errors++; $display("FAIL fpr_write: got %0d/%h required %0d/%h", wb.fpr_waddr, wb.fpr_wdata, me.waddr, me.wdata);
            end
          end
          checks++;
          if (wb.x_result.id !== me.id) begin
            errors++; $display("FAIL x_id: got %0d required %0d", wb.x_result.id, me.id);
          end
          checks++;
          if (wb.x_result.we !== me.xwe) begin
            errors++; $display("FAIL x_we: got %b required %b", wb.x_result.we, me.xwe);
          end
          if (me.chk_x) begin
            checks++;
            if ({wb.x_result.rd, wb.x_result.data} !== {me.xrd, me.xdata}) begin
              errors++; $display("FAIL x_rd_data: got %0d/%h required %0d/%h", wb.x_result.rd, wb.x_result.data, me.xrd, me.xdata);
            end
          end
          checks++;
          if ({wb.x_result.ecswe, wb.x_result.err} !== {me.ecswe, me.err}) begin
            errors++; $display("FAIL x_ecswe_err: got %b/%b required %b/%b", wb.x_result.ecswe, wb.x_result.err, me.ecswe, me.err);
          end
          checks++;
          if ({wb.x_result.exc, wb.x_result.exccode, wb.x_result.dbg} !== 8'd0) begin
            errors++; $display("FAIL x_exc: got %b/%h/%b required 0", wb.x_result.exc, wb.x_result.exccode, wb.x_result.dbg);
          end
          checks++;
          if ({wb.fflags_we, wb.fflags} !== {me.fflags_we, me.fflags}) begin
            errors++; $display("FAIL fflags: got we=%b %b required we=%b %b", wb.fflags_we, wb.fflags, me.fflags_we, me.fflags);
          end
        end
      end else begin
        checks++;
        if ({wb.fpr_we, wb.fflags_we} !== 2'b00) begin
          errors++; $display("FAIL idle_strobe: got fpr_we=%b fflags_we=%b required 0", wb.fpr_we, wb.fflags_we);
        end
      end
    end
  end

  task automatic drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      @(posedge clk); k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_timeout: got %0d pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic set_fpu(logic [4:0] addr, logic is_fp, logic [3:0] id, logic [31:0] res, logic [4:0] st);
    fpu_valid = 1'b1; fpu_result = res; fpu_status = st;
    fpu_tag = '{addr: addr, rd_is_fp: is_fp, id: id};
  endtask

  task automatic set_mem(logic [4:0] rd, logic we, logic [3:0] id, logic [31:0] rdata, logic err);
    mem_valid = 1'b1; mem_rdata = rdata; mem_err = err;
    mem_meta = '{id: id, rd: rd, we: we, be: 4'hf};
  endtask

  task automatic test_reset();
    rst = 1'b1; fpu_valid = 1'b1; mem_valid = 1'b1; wb.x_result_ready = 1'b1;
    fpu_result = 32'h1; fpu_tag = '0; fpu_status = 5'h1f;
    mem_rdata = 32'h2; mem_meta = '0; mem_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({wb.x_result_valid, busy, wb.fpr_we, wb.fflags_we, wb.x_result} !== '0) begin
        errors++; $display("FAIL reset_outputs: got valid=%b busy=%b fpr_we=%b required all 0", wb.x_result_valid, busy, wb.fpr_we);
      end
    end
    @(posedge clk); #1 rst = 1'b0; fpu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({fpu_ready, mem_ready, busy, wb.x_result_valid} !== 4'b1100) begin
      errors++; $display("FAIL after_reset: got rdy=%b%b busy=%b valid=%b required 1100", fpu_ready, mem_ready, busy, wb.x_result_valid);
    end
  endtask

  task automatic test_fpu_single(logic [4:0] addr, logic is_fp, logic [3:0] id, logic [31:0] res, logic [4:0] st);
    @(posedge clk); #1;
    set_fpu(addr, is_fp, id, res, st);
    exp_q.push_back(exp_fpu(addr, is_fp, id, res, st));
    @(negedge clk);
    checks++;
    if ({wb.x_result_valid, fpu_ready} !== 2'b01) begin
      errors++; $display("FAIL fpu_latency: got valid=%b ready=%b required 0/1", wb.x_result_valid, fpu_ready);
    end
    @(posedge clk); #1 fpu_valid = 1'b0;
    drain("fpu_single");
  endtask

  task automatic test_contention();
    pulse_reset();
    @(posedge clk); #1;
    set_fpu(5'd1, 1'b1, 4'd4, 32'h3f800000, 5'b00000);
    set_mem(5'd7, 1'b1, 4'd5, 32'hc0000000, 1'b0);
    exp_q.push_back(exp_fpu(5'd1, 1'b1, 4'd4, 32'h3f800000, 5'b00000));
    exp_q.push_back(exp_mem(5'd7, 1'b1, 4'd5, 32'hc0000000, 1'b0));
    @(posedge clk); #1 fpu_valid = 1'b0; mem_valid = 1'b0;
    drain("contention_a");
    // A lone FPU retirement leaves the pointer on MEM for the next tie.
    @(posedge clk); #1;
    set_fpu(5'd2, 1'b0, 4'd6, 32'h11, 5'b10000);
    exp_q.push_back(exp_fpu(5'd2, 1'b0, 4'd6, 32'h11, 5'b10000));
    @(posedge clk); #1 fpu_valid = 1'b0;
    drain("contention_b");
    @(posedge clk); #1;
    set_fpu(5'd3, 1'b1, 4'd7, 32'h22, 5'b00100);
    set_mem(5'd8, 1'b1, 4'd8, 32'h33, 1'b0);
    exp_q.push_back(exp_mem(5'd8, 1'b1, 4'd8, 32'h33, 1'b0));
    exp_q.push_back(exp_fpu(5'd3, 1'b1, 4'd7, 32'h22, 5'b00100));
    @(posedge clk); #1 fpu_valid = 1'b0; mem_valid = 1'b0;
    drain("contention_c");
  endtask

  task automatic test_backpressure();
    int r0;
    pulse_reset();
    @(posedge clk); #1;
    wb.x_result_ready = 1'b0;
    set_fpu(5'd9, 1'b1, 4'd10, 32'hdeadbeef, 5'b00010);
    set_mem(5'd11, 1'b1, 4'd11, 32'hcafef00d, 1'b0);
    @(posedge clk); #1 fpu_valid = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({wb.x_result_valid, fpu_ready, mem_ready, busy} !== 4'b1001) begin
        errors++; $display("FAIL bp_handshake: got valid=%b rdy=%b%b busy=%b required 1/00/1", wb.x_result_valid, fpu_ready, mem_ready, busy);
      end
      checks++;
      if ({wb.x_result.id, wb.x_result.data} !== {4'd10, 32'hdeadbeef}) begin
        errors++; $display("FAIL bp_payload: got id=%0d data=%h required id=10 data=deadbeef", wb.x_result.id, wb.x_result.data);
      end
    end
    @(posedge clk); #1;
    r0 = n_ret;
    wb.x_result_ready = 1'b1;
    exp_q.push_back(exp_fpu(5'd9, 1'b1, 4'd10, 32'hdeadbeef, 5'b00010));
    exp_q.push_back(exp_mem(5'd11, 1'b1, 4'd11, 32'hcafef00d, 1'b0));
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (n_ret !== r0 + 2) begin
      errors++; $display("FAIL bp_release: got %0d retirements required 2", n_ret - r0);
    end
    drain("backpressure");
  endtask

  task automatic test_load_error();
    @(posedge clk); #1;
    set_mem(5'd2, 1'b1, 4'd9, 32'h3f800000, 1'b1);
    exp_q.push_back(exp_mem(5'd2, 1'b1, 4'd9, 32'h3f800000, 1'b1));
    @(posedge clk); #1 mem_valid = 1'b0; mem_err = 1'b0;
    drain("load_error");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    wb.x_result_ready = 1'b0;
    set_fpu(5'd4, 1'b1, 4'd12, 32'h55, 5'b0);
    set_mem(5'd5, 1'b1, 4'd13, 32'h66, 1'b0);
    @(posedge clk); #1 fpu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, fpu_ready, mem_ready} !== 3'b100) begin
      errors++; $display("FAIL mid_full: got busy=%b rdy=%b%b required 1/00", busy, fpu_ready, mem_ready);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; wb.x_result_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, wb.x_result_valid, fpu_ready, mem_ready} !== 4'b0011) begin
      errors++; $display("FAIL mid_reset: got busy=%b valid=%b rdy=%b%b required 0/0/11", busy, wb.x_result_valid, fpu_ready, mem_ready);
    end
  endtask

  initial begin
    test_reset();
    test_fpu_single(5'd5, 1'b1, 4'd3, 32'h40400000, 5'b00001);
    test_fpu_single(5'd10, 1'b0, 4'd1, 32'd7, 5'b00000);
    test_contention();
    test_backpressure();
    test_load_error();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
